phase_ctrl: RTL

Synthesizable two-phase non-overlapping clock sequencer for the lab datapath. It runs from one fast system clock and drives `phi1`/`phi2` as registered phase enables, with programmable high time and non-overlap gap. Software-style controls are provided: start, stop-at-cycle-boundary and single-step. It sits between the top-level test harness and the two-phase latch datapath, and it is the only source of phase enables in the design.

---
 rtl/phase_ctrl_pkg.sv | 19 +
 rtl/phase_ctrl_timer.sv | 27 ++
 rtl/phase_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/phase_ctrl_pkg.sv
// Shared types and constants for the two-phase non-overlapping clock sequencer.
package phase_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GAP_A = 3'd1,
      PH2   = 3'd2,
      GAP_B = 3'd3,
      PH1   = 3'd4
   } state_e;

   typedef enum logic {
      RUN    = 1'b0,
      SINGLE = 1'b1
   } mode_e;

   localparam int unsigned MIN_DUR = 1;

endpackage

// File: rtl/phase_ctrl_timer.sv
// Loadable down-counter timing each phase; expire flags the final cycle of a phase.
module phase_timer #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire
);

   logic [CNT_W-1:0] cnt_q;

   // Loading D at phase entry makes the phase last exactly D cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

   assign expire = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/phase_ctrl.sv
// Two-phase non-overlapping phase-enable sequencer with programmable high time and gap,
// start / stop-at-boundary / single-step controls and a completed-cycle counter.
module phase_ctrl
   import phase_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned CYC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_gap,
   input  logic             start,
   input  logic             stop,
   input  logic             step,
   output logic             phi1,
   output logic             phi2,
   output logic             busy,
   output logic             done,
   output logic [CYC_W-1:0] cycle_cnt
);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic             stop_pend_q;
   logic [CNT_W-1:0] hi_q, gap_q;
   logic [CNT_W-1:0] hi_in, gap_in;
   logic             tmr_load, tmr_expire;
   logic [CNT_W-1:0] tmr_val;
   logic             latch, fin, inc;

   assign hi_in  = (cfg_high == '0) ? CNT_W'(MIN_DUR) : cfg_high;
   assign gap_in = (cfg_gap == '0) ? CNT_W'(MIN_DUR) : cfg_gap;

   phase_timer #(
      .CNT_W(CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .load_val(tmr_val),
      .expire  (tmr_expire)
   );

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      tmr_load = 1'b0;
      tmr_val  = gap_q;
      latch    = 1'b0;
      fin      = 1'b0;
      inc      = 1'b0;
      case (state_q)
         IDLE: begin
            if (start || step) begin
               state_d  = GAP_A;
               mode_d   = (step || stop) ? SINGLE : RUN;
               tmr_load = 1'b1;
               tmr_val  = gap_in;
               latch    = 1'b1;
            end
         end
         GAP_A: begin
            if (tmr_expire) begin
               state_d  = PH2;
               tmr_load = 1'b1;
               tmr_val  = hi_q;
            end
         end
         PH2: begin
            if (tmr_expire) begin
               state_d  = GAP_B;
               tmr_load = 1'b1;
               tmr_val  = gap_q;
            end
         end
         GAP_B: begin
            if (tmr_expire) begin
               state_d  = PH1;
               tmr_load = 1'b1;
               tmr_val  = hi_q;
            end
         end
         PH1: begin
            if (tmr_expire) begin
               inc = 1'b1;
               // A stop seen in the very last PH1 cycle still ends the run here.
               if (mode_q == SINGLE || stop_pend_q || stop) begin
                  state_d = IDLE;
                  fin     = 1'b1;
               end else begin
                  state_d  = GAP_A;
                  tmr_load = 1'b1;
                  tmr_val  = gap_in;
                  latch    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so phi1/phi2 can never overlap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= RUN;
         stop_pend_q <= 1'b0;
         hi_q        <= CNT_W'(MIN_DUR);
         gap_q       <= CNT_W'(MIN_DUR);
         phi1        <= 1'b0;
         phi2        <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         cycle_cnt   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         phi1    <= (state_d == PH1);
         phi2    <= (state_d == PH2);
         busy    <= (state_d != IDLE);
         done    <= fin;
         if (inc) begin
            cycle_cnt <= cycle_cnt + CYC_W'(1);
         end
         if (latch) begin
            hi_q  <= hi_in;
            gap_q <= gap_in;
         end
         if (fin) begin
            stop_pend_q <= 1'b0;
         end else if (stop && state_q != IDLE) begin
            stop_pend_q <= 1'b1;
         end
      end
   end

endmodule
